// File: rtl/osc_array_trng_pkg.sv
// osc_trng_pkg: shared definitions for the oscillator-array TRNG.
//   - trng_state_e : sequencer states
//   - ARM_*        : arm levels applied to even/odd cells during ARM and RUN
//   - phase_w()    : width of the phase counter for the given phase lengths
package osc_trng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    ARM,
    RUN,
    SAMPLE,
    OUT
  } trng_state_e;

  localparam logic ARM_EVEN_I1 = 1'b1;
  localparam logic ARM_EVEN_I2 = 1'b0;
  localparam logic ARM_ODD_I1  = 1'b0;
  localparam logic ARM_ODD_I2  = 1'b1;

  function automatic int unsigned phase_w(input int unsigned rst_cyc,
                                          input int unsigned arm_cyc,
                                          input int unsigned run_cyc);
    int unsigned m;
    m = rst_cyc;
    if (arm_cyc > m) m = arm_cyc;
    if (run_cyc > m) m = run_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/osc_array_trng_if.sv
// osc_array_trng_if: word read handshake between the TRNG and its consumer.
//   rd_data  : random word
//   rd_valid : rd_data valid (held until accepted)
//   rd_ready : consumer accept
// master = TRNG side, slave = consumer side.
interface osc_array_trng_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  modport master (output rd_data, output rd_valid, input rd_ready);
  modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/osc_array_trng_sync.sv
// trng_sync: per-bit flop chain bringing asynchronous oscillator outputs
// into the clk domain.
//   clk, rst : clock, synchronous active-high reset (clears every stage)
//   d        : asynchronous input bits
//   q        : synchronised output, STAGES cycles behind d
module trng_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] ff [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) ff[i] <= '0;
    end else begin
      ff[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/osc_array_trng.sv
// osc_array_trng: sequencer and harvester for an array of cross-coupled
// oscillator cells. Each bit: reset cells, arm them, trigger and free-run,
// then XOR-reduce the synchronised cell outputs into one raw bit. WORD_W raw
// bits (first bit = MSB) form a word delivered over a valid/ready handshake.
//   clk, rst        : clock, synchronous active-high reset
//   en, mode        : enable; 0 = continuous, 1 = one word per en rising edge
//   osc_in          : asynchronous cell outputs
//   cell_t          : shared trigger to all cells
//   cell_i1/cell_i2 : per-cell arm inputs
//   rd              : word handshake (master side)
//   busy            : sequencer not idle
//   health_fail     : sticky repetition-count failure
// Build option: define OSC_HEALTH_EN to enable the repetition-count health
// test; otherwise health_fail is tied low.
module osc_array_trng
  import osc_trng_pkg::*;
#(
  parameter int unsigned N_CELLS     = 4,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned RST_CYC     = 2,
  parameter int unsigned ARM_CYC     = 2,
  parameter int unsigned RUN_CYC     = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned REP_LIMIT   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [N_CELLS-1:0] osc_in,
  output logic               cell_t,
  output logic [N_CELLS-1:0] cell_i1,
  output logic [N_CELLS-1:0] cell_i2,
  osc_array_trng_if.master   rd,
  output logic               busy,
  output logic               health_fail
);

  localparam int unsigned PH_W = phase_w(RST_CYC, ARM_CYC, RUN_CYC);
  localparam int unsigned BC_W = $clog2(WORD_W + 1);

  if (RUN_CYC < SYNC_STAGES + 1 || REP_LIMIT < 1) begin : g_cfg_check
    $error("osc_array_trng: RUN_CYC must exceed SYNC_STAGES and REP_LIMIT must be nonzero");
  end

  trng_state_e        state_q, state_d;
  logic [PH_W-1:0]    ph_q;
  logic [BC_W-1:0]    bit_cnt_q;
  logic [WORD_W-1:0]  shreg_q;
  logic [WORD_W-1:0]  rd_data_q;
  logic               rd_valid_q;
  logic               mode_q;
  logic               en_q;
  logic [N_CELLS-1:0] osc_s;
  logic [N_CELLS-1:0] arm_i1, arm_i2;
  logic               raw;
  logic               word_done;
  logic               discard;
  logic               health_trip;
  logic               hf_block;

  trng_sync #(
    .WIDTH (N_CELLS),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (osc_in),
    .q  (osc_s)
  );

  assign raw       = ^osc_s;
  assign word_done = (bit_cnt_q == BC_W'(WORD_W - 1));
  // A completed word is thrown away while the health test is failing.
  assign discard   = health_trip || (word_done && hf_block);

  always_comb begin
    arm_i1 = '0;
    arm_i2 = '0;
    for (int unsigned c = 0; c < N_CELLS; c++) begin
      arm_i1[c] = (c % 2 == 0) ? ARM_EVEN_I1 : ARM_ODD_I1;
      arm_i2[c] = (c % 2 == 0) ? ARM_EVEN_I2 : ARM_ODD_I2;
    end
  end

  function automatic logic [PH_W-1:0] ph_load(input trng_state_e s);
    case (s)
      CRST:    ph_load = PH_W'(RST_CYC - 1);
      ARM:     ph_load = PH_W'(ARM_CYC - 1);
      RUN:     ph_load = PH_W'(RUN_CYC - 1);
      default: ph_load = '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cell_t  = 1'b0;
    cell_i1 = '0;
    cell_i2 = '0;
    case (state_q)
      IDLE: if (en && (!mode || !en_q)) state_d = CRST;
      CRST: begin
        if (!en) state_d = IDLE;
        else if (ph_q == '0) state_d = ARM;
      end
      ARM: begin
        cell_i1 = arm_i1;
        cell_i2 = arm_i2;
        if (!en) state_d = IDLE;
        else if (ph_q == '0) state_d = RUN;
      end
      RUN: begin
        cell_t  = 1'b1;
        cell_i1 = arm_i1;
        cell_i2 = arm_i2;
        if (!en) state_d = IDLE;
        else if (ph_q == '0) state_d = SAMPLE;
      end
      SAMPLE: begin
        cell_i1 = arm_i1;
        cell_i2 = arm_i2;
        if (!en) state_d = IDLE;
        else if (word_done && !discard) state_d = OUT;
        else state_d = CRST;
      end
      OUT: if (rd_valid_q && rd.rd_ready) state_d = (!mode_q && en) ? CRST : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      mode_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en;
      if (state_d != state_q) ph_q <= ph_load(state_d);
      else if (ph_q != '0) ph_q <= ph_q - PH_W'(1);
      if (state_q == IDLE && state_d == CRST) mode_q <= mode;
      if (state_d == IDLE || (state_q == OUT && state_d != OUT)) begin
        bit_cnt_q <= '0;
        shreg_q   <= '0;
      end else if (state_q == SAMPLE) begin
        if (discard) begin
          bit_cnt_q <= '0;
          shreg_q   <= '0;
        end else begin
          bit_cnt_q <= bit_cnt_q + BC_W'(1);
          shreg_q   <= {shreg_q[WORD_W-2:0], raw};
        end
      end
      // The word is latched on the first OUT cycle, then held until accepted.
      if (state_q == OUT) begin
        if (!rd_valid_q) begin
          rd_data_q  <= shreg_q;
          rd_valid_q <= 1'b1;
        end else if (rd.rd_ready) begin
          rd_valid_q <= 1'b0;
        end
      end
    end
  end

`ifdef OSC_HEALTH_EN
  localparam int unsigned RC_W = $clog2(REP_LIMIT + 1);
  logic [RC_W-1:0] rep_q, rep_next;
  logic            last_q, hf_q;

  always_comb begin
    rep_next = RC_W'(1);
    if (rep_q != '0 && raw == last_q) rep_next = rep_q + RC_W'(1);
  end

  assign health_trip = (state_q == SAMPLE) && (rep_next == RC_W'(REP_LIMIT));
  assign hf_block    = hf_q;
  assign health_fail = hf_q;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      rep_q  <= '0;
      last_q <= 1'b0;
      hf_q   <= 1'b0;
    end else if (state_q == SAMPLE) begin
      last_q <= raw;
      rep_q  <= health_trip ? '0 : rep_next;
      if (health_trip) hf_q <= 1'b1;
    end
  end
`else
  assign health_trip = 1'b0;
  assign hf_block    = 1'b0;
  assign health_fail = 1'b0;
`endif

  assign rd.rd_data  = rd_data_q;
  assign rd.rd_valid = rd_valid_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_osc_array_trng.sv
// Directed bench for osc_array_trng with N_CELLS=2, WORD_W=8, phases 2/2/4/1.
module tb_osc_array_trng;

  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [1:0] osc_in;
  logic       cell_t;
  logic [1:0] cell_i1, cell_i2;
  logic       busy, health_fail;
  int         total = 0;
  int         bad   = 0;

  osc_array_trng_if #(.WORD_W(8)) rd_if ();

  osc_array_trng #(
    .N_CELLS    (2),
    .WORD_W     (8),
    .RST_CYC    (2),
    .ARM_CYC    (2),
    .RUN_CYC    (4),
    .SYNC_STAGES(2),
    .REP_LIMIT  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .osc_in     (osc_in),
    .cell_t     (cell_t),
    .cell_i1    (cell_i1),
    .cell_i2    (cell_i2),
    .rd         (rd_if),
    .busy       (busy),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cell output pattern giving the requested raw (XOR) bit; encoding varies per bit.
  function automatic logic [1:0] enc(input logic r, input int b);
    if (r) return b[0] ? 2'b10 : 2'b01;
    return b[0] ? 2'b11 : 2'b00;
  endfunction

  // Entered in cycle 0 of a word (CRST just entered); returns in cycle 72 (OUT).
  task automatic run_word(input logic [7:0] pat);
    for (int b = 0; b < 8; b++) begin
      osc_in = enc(pat[7-b], b);
      repeat (9) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b0; osc_in = 2'b00; rd_if.rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (cell_t !== 1'b0) begin bad++; $display("FAIL reset_cell_t got=%b exp=0", cell_t); end
      total++; if ({cell_i1, cell_i2} !== 4'b0) begin bad++; $display("FAIL reset_arm got=%b exp=0000", {cell_i1, cell_i2}); end
      total++; if (rd_if.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rd_if.rd_valid); end
      total++; if (rd_if.rd_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rd_if.rd_data); end
      total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL reset_health got=%b exp=0", health_fail); end
    end
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_release_busy got=%b exp=1", busy); end
    en = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_known_pattern();
    logic [7:0] pat;
    logic       exp_t;
    logic [1:0] exp_i1, exp_i2;
    pat = 8'hB2;
    mode = 1'b0; rd_if.rd_ready = 1'b1; en = 1'b1;
    tick();
    for (int b = 0; b < 8; b++) begin
      osc_in = enc(pat[7-b], b);
      for (int c = 0; c < 9; c++) begin
        exp_t  = (c >= 4 && c <= 7);
        exp_i1 = (c >= 2) ? 2'b01 : 2'b00;
        exp_i2 = (c >= 2) ? 2'b10 : 2'b00;
        total++; if (cell_t !== exp_t) begin bad++; $display("FAIL phase_t bit=%0d cyc=%0d got=%b exp=%b", b, c, cell_t, exp_t); end
        if (c < 8) begin
          total++; if (cell_i1 !== exp_i1 || cell_i2 !== exp_i2)
            begin bad++; $display("FAIL phase_arm bit=%0d cyc=%0d got=%b/%b exp=%b/%b", b, c, cell_i1, cell_i2, exp_i1, exp_i2); end
        end
        total++; if (rd_if.rd_valid !== 1'b0) begin bad++; $display("FAIL early_valid bit=%0d cyc=%0d got=1 exp=0", b, c); end
        tick();
      end
    end
    total++; if (rd_if.rd_valid !== 1'b0) begin bad++; $display("FAIL out_entry_valid got=%b exp=0", rd_if.rd_valid); end
    total++; if (cell_t !== 1'b0 || cell_i1 !== 2'b00) begin bad++; $display("FAIL out_cells got=%b/%b exp=0/00", cell_t, cell_i1); end
    tick();
    total++; if (rd_if.rd_valid !== 1'b1) begin bad++; $display("FAIL word_valid got=%b exp=1", rd_if.rd_valid); end
    total++; if (rd_if.rd_data !== 8'hB2) begin bad++; $display("FAIL word_data got=%h exp=b2", rd_if.rd_data); end
    tick();
    total++; if (rd_if.rd_valid !== 1'b0) begin bad++; $display("FAIL valid_pulse got=%b exp=0", rd_if.rd_valid); end
    total++; if (busy !== 1'b1 || cell_i1 !== 2'b00) begin bad++; $display("FAIL restart_crst got=%b/%b exp=1/00", busy, cell_i1); end
  endtask

  task automatic test_backpressure();
    rd_if.rd_ready = 1'b0;
    run_word(8'hB2);
    tick();
    for (int i = 0; i < 20; i++) begin
      total++; if (rd_if.rd_valid !== 1'b1) begin bad++; $display("FAIL bp_valid i=%0d got=%b exp=1", i, rd_if.rd_valid); end
      total++; if (rd_if.rd_data !== 8'hB2) begin bad++; $display("FAIL bp_data i=%0d got=%h exp=b2", i, rd_if.rd_data); end
      total++; if (cell_t !== 1'b0) begin bad++; $display("FAIL bp_cell_t i=%0d got=%b exp=0", i, cell_t); end
      tick();
    end
    rd_if.rd_ready = 1'b1;
    tick();
    total++; if (rd_if.rd_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", rd_if.rd_valid); end
    total++; if (busy !== 1'b1 || cell_i1 !== 2'b00) begin bad++; $display("FAIL bp_crst got=%b/%b exp=1/00", busy, cell_i1); end
    tick();
    tick();
    total++; if (cell_i1 !== 2'b01 || cell_i2 !== 2'b10) begin bad++; $display("FAIL bp_arm got=%b/%b exp=01/10", cell_i1, cell_i2); end
  endtask

  // Entered in cycle 2 of a word; aborts in the 5th RUN (cycle 41).
  task automatic test_abort();
    osc_in = 2'b01;
    repeat (39) tick();
    total++; if (cell_t !== 1'b1) begin bad++; $display("FAIL abort_in_run got=%b exp=1", cell_t); end
    en = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", busy); end
    total++; if ({cell_t, cell_i1, cell_i2} !== 5'b0) begin bad++; $display("FAIL abort_cells got=%b exp=00000", {cell_t, cell_i1, cell_i2}); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rd_if.rd_valid !== 1'b0 || busy !== 1'b0)
        begin bad++; $display("FAIL abort_quiet i=%0d got=%b/%b exp=0/0", i, rd_if.rd_valid, busy); end
      tick();
    end
    en = 1'b1;
    tick();
    run_word(8'h5C);
    tick();
    total++; if (rd_if.rd_valid !== 1'b1) begin bad++; $display("FAIL abort_fresh_valid got=%b exp=1", rd_if.rd_valid); end
    total++; if (rd_if.rd_data !== 8'h5C) begin bad++; $display("FAIL abort_fresh_data got=%h exp=5c", rd_if.rd_data); end
    en = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || rd_if.rd_valid !== 1'b0)
      begin bad++; $display("FAIL out_en_low got=%b/%b exp=0/0", busy, rd_if.rd_valid); end
  endtask

  task automatic test_one_shot();
    mode = 1'b1; en = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL os_start got=%b exp=1", busy); end
    run_word(8'hA7);
    tick();
    total++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 8'hA7)
      begin bad++; $display("FAIL os_word1 got=%b/%h exp=1/a7", rd_if.rd_valid, rd_if.rd_data); end
    tick();
    for (int i = 0; i < 20; i++) begin
      total++; if (busy !== 1'b0 || rd_if.rd_valid !== 1'b0)
        begin bad++; $display("FAIL os_hold_idle i=%0d got=%b/%b exp=0/0", i, busy, rd_if.rd_valid); end
      tick();
    end
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL os_retrigger got=%b exp=1", busy); end
    run_word(8'h3C);
    tick();
    total++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 8'h3C)
      begin bad++; $display("FAIL os_word2 got=%b/%h exp=1/3c", rd_if.rd_valid, rd_if.rd_data); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL os_end_idle got=%b exp=0", busy); end
    en = 1'b0; mode = 1'b0;
    tick();
  endtask

`ifdef OSC_HEALTH_EN
  task automatic test_health();
    en = 1'b1; osc_in = 2'b01;
    tick();
    for (int i = 0; i < 72; i++) begin
      total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL hf_early cyc=%0d got=1 exp=0", i); end
      tick();
    end
    total++; if (health_fail !== 1'b1) begin bad++; $display("FAIL hf_set got=%b exp=1", health_fail); end
    for (int i = 0; i < 100; i++) begin
      total++; if (rd_if.rd_valid !== 1'b0) begin bad++; $display("FAIL hf_no_valid i=%0d got=1 exp=0", i); end
      tick();
    end
    en = 1'b0;
    tick();
    total++; if (health_fail !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL hf_clear got=%b/%b exp=0/0", health_fail, busy); end
  endtask
`else
  task automatic test_health();
    en = 1'b1; osc_in = 2'b01;
    tick();
    for (int i = 0; i < 72; i++) tick();
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL hf_tied got=%b exp=0", health_fail); end
    tick();
    total++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 8'hFF)
      begin bad++; $display("FAIL const_word got=%b/%h exp=1/ff", rd_if.rd_valid, rd_if.rd_data); end
    en = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL const_end_idle got=%b exp=0", busy); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_known_pattern();
    test_backpressure();
    test_abort();
    test_one_shot();
    test_health();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
